// File: rtl/mul_div_pkg.sv
// Shared definitions for the sequential multiply/divide unit: default operand
// width, iteration counter width and the control FSM encoding.
package mul_div_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int CNT_W         = $clog2(DEFAULT_WIDTH);

    // Common to the multiplier and the divider control so both issue identically.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mul_adder.sv
// Combinational WIDTH-bit unsigned adder with carry out; mirrors the divider's
// ALU shape so the two datapaths stay interchangeable.
module mul_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    assign {carry, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/seq_multiplier.sv
// Sequential unsigned shift-add multiplier: retires one multiplier bit per clock
// and returns the exact 2*WIDTH-bit product under a Run/Ready handshake.
module seq_multiplier
    import mul_div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               Reset,
    input  logic               Run,
    input  logic [WIDTH-1:0]   Multiplicand,
    input  logic [WIDTH-1:0]   Multiplier,
    output logic [2*WIDTH-1:0] Product,
    output logic               Ready
);

    localparam int            CNT_BITS = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_BITS-1:0] LAST_CNT = CNT_BITS'(WIDTH - 1);

    state_t              state, state_nxt;
    logic [CNT_BITS-1:0] cnt;
    logic [WIDTH-1:0]    mcand;
    logic [WIDTH-1:0]    hi;
    logic [WIDTH-1:0]    lo;
    logic                carry;
    logic                ready_q;

    logic                load;
    logic                step;
    logic                last;

    logic [WIDTH-1:0]    add_sum;
    logic                add_carry;
    logic [WIDTH:0]      sum_ext;
    logic [2*WIDTH:0]    shift_nxt;

    mul_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a     (hi),
        .b     (mcand),
        .sum   (add_sum),
        .carry (add_carry)
    );

    // Keep the adder carry: hi + mcand can overflow WIDTH bits.
    assign sum_ext   = lo[0] ? {add_carry, add_sum} : {1'b0, hi};
    assign shift_nxt = {1'b0, sum_ext, lo[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                if (Run) begin
                    load      = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                // Run is deliberately ignored here: no restart, no resample.
                step = 1'b1;
                if (cnt == LAST_CNT) begin
                    last      = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (Run) begin
                    load      = 1'b1;
                    state_nxt = BUSY;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!Reset) begin
            cnt     <= '0;
            mcand   <= '0;
            hi      <= '0;
            lo      <= '0;
            carry   <= 1'b0;
            ready_q <= 1'b0;
        end else if (load) begin
            cnt     <= '0;
            mcand   <= Multiplicand;
            hi      <= '0;
            lo      <= Multiplier;
            carry   <= 1'b0;
            ready_q <= 1'b0;
        end else if (step) begin
            {carry, hi, lo} <= shift_nxt;
            cnt             <= cnt + CNT_BITS'(1);
            if (last) begin
                ready_q <= 1'b1;
            end
        end
    end

    // carry is the top of the (2*WIDTH+1)-bit shift register; it always shifts in 0.
    logic unused_carry;
    assign unused_carry = carry;

    assign Product = {hi, lo};
    assign Ready   = ready_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard-driven bench for seq_multiplier: expected products are queued at
// each load edge and compared when Ready is observed.
module tb_seq_multiplier;
    import mul_div_pkg::*;

    localparam int W = 32;

    logic           clk;
    logic           Reset;
    logic           Run;
    logic [W-1:0]   Multiplicand;
    logic [W-1:0]   Multiplier;
    logic [2*W-1:0] Product;
    logic           Ready;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [2*W-1:0] sb[$];

    seq_multiplier #(.WIDTH(W)) dut (
        .clk          (clk),
        .Reset        (Reset),
        .Run          (Run),
        .Multiplicand (Multiplicand),
        .Multiplier   (Multiplier),
        .Product      (Product),
        .Ready        (Ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a one-cycle Run pulse; returns after the load edge.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit keep_run);
        Multiplicand = a;
        Multiplier   = b;
        Run          = 1'b1;
        sb.push_back({32'd0, a} * {32'd0, b});
        tick();
        if (!keep_run) Run = 1'b0;
    endtask

    // Counts edges after the load edge until Ready; lat = -1 if the budget expires.
    task automatic wait_ready(output int lat, output logic [2*W-1:0] prod);
        lat  = -1;
        prod = 'x;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (Ready === 1'b1) begin
                lat  = i;
                prod = Product;
                break;
            end
        end
    endtask

    task automatic test_reset();
        Reset        = 1'b0;
        Run          = 1'b1;
        Multiplicand = $urandom;
        Multiplier   = $urandom;
        tick();
        tick();
        n_cmp++;
        if (Product !== 64'd0) begin
            n_fail++; $display("FAIL reset_product: got %h want 0", Product);
        end
        n_cmp++;
        if (Ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_ready: got %b want 0", Ready);
        end
        n_cmp++;
        if (dut.state !== IDLE) begin
            n_fail++; $display("FAIL reset_state: got %0d want IDLE", dut.state);
        end
        Run   = 1'b0;
        Reset = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int lat; logic [2*W-1:0] prod, exp;
        start_op(32'd6, 32'd7, 1'b0);
        Multiplicand = $urandom;
        Multiplier   = $urandom;
        wait_ready(lat, prod);
        exp = sb.pop_front();
        n_cmp++;
        if (lat !== 32) begin
            n_fail++; $display("FAIL basic_latency: got %0d want 32", lat);
        end
        n_cmp++;
        if (prod !== exp) begin
            n_fail++; $display("FAIL basic_product: got %h want %h", prod, exp);
        end
        n_cmp++;
        if (prod !== 64'h2A) begin
            n_fail++; $display("FAIL basic_const: got %h want 2a", prod);
        end
    endtask

    task automatic test_carry();
        int lat; logic [2*W-1:0] prod, exp;
        logic [W-1:0] a_v[2] = '{32'hFFFFFFFF, 32'h80000000};
        logic [W-1:0] b_v[2] = '{32'hFFFFFFFF, 32'd2};
        logic [2*W-1:0] k_v[2] = '{64'hFFFFFFFE_00000001, 64'h1_00000000};
        for (int t = 0; t < 2; t++) begin
            start_op(a_v[t], b_v[t], 1'b0);
            wait_ready(lat, prod);
            exp = sb.pop_front();
            n_cmp++;
            if (prod !== exp || prod !== k_v[t]) begin
                n_fail++; $display("FAIL carry_%0d: got %h want %h", t, prod, k_v[t]);
            end
        end
    endtask

    task automatic test_random();
        int lat; logic [2*W-1:0] prod, exp;
        for (int t = 0; t < 4; t++) begin
            start_op($urandom, $urandom, 1'b0);
            wait_ready(lat, prod);
            exp = sb.pop_front();
            n_cmp++;
            if (lat !== 32 || prod !== exp) begin
                n_fail++; $display("FAIL random_%0d: got %h lat %0d want %h lat 32", t, prod, lat, exp);
            end
        end
    endtask

    task automatic test_run_busy();
        int lat; logic [2*W-1:0] prod, exp;
        start_op(32'd3, 32'd5, 1'b0);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (i == 10) begin
                Run = 1'b1; Multiplicand = 32'd9; Multiplier = 32'd9;
            end else begin
                Run = 1'b0;
            end
            if (Ready === 1'b1) begin
                lat = i; prod = Product; break;
            end
        end
        exp = sb.pop_front();
        n_cmp++;
        if (lat !== 32) begin
            n_fail++; $display("FAIL busy_latency: got %0d want 32", lat);
        end
        n_cmp++;
        if (prod !== exp) begin
            n_fail++; $display("FAIL busy_product: got %h want %h", prod, exp);
        end
        for (int i = 0; i < 3; i++) tick();
        n_cmp++;
        if (Ready !== 1'b1 || Product !== 64'd15) begin
            n_fail++; $display("FAIL busy_no_restart: got ready %b product %h want 1 f", Ready, Product);
        end
    endtask

    task automatic test_reset_mid();
        int lat; logic [2*W-1:0] prod, exp;
        start_op(32'h1234, 32'h5678, 1'b0);
        for (int i = 1; i <= 12; i++) tick();
        Reset = 1'b0;
        tick();
        sb.delete();
        n_cmp++;
        if (Ready !== 1'b0 || Product !== 64'd0 || dut.state !== IDLE) begin
            n_fail++; $display("FAIL midreset: got ready %b product %h state %0d want 0 0 IDLE",
                               Ready, Product, dut.state);
        end
        Reset = 1'b1;
        tick();
        start_op(32'h1234, 32'h5678, 1'b0);
        wait_ready(lat, prod);
        exp = sb.pop_front();
        n_cmp++;
        if (lat !== 32 || prod !== exp || prod !== 64'h06260060) begin
            n_fail++; $display("FAIL midreset_followup: got %h lat %0d want 06260060 lat 32", prod, lat);
        end
    endtask

    task automatic test_back_to_back();
        int lat; logic [2*W-1:0] prod, exp;
        start_op(32'h12345678, 32'd0, 1'b1);
        Multiplicand = 32'd1;
        Multiplier   = 32'hDEADBEEF;
        wait_ready(lat, prod);
        exp = sb.pop_front();
        n_cmp++;
        if (lat !== 32 || prod !== exp) begin
            n_fail++; $display("FAIL b2b_first: got %h lat %0d want %h lat 32", prod, lat, exp);
        end
        sb.push_back(64'hDEADBEEF);
        tick();
        n_cmp++;
        if (Ready !== 1'b0) begin
            n_fail++; $display("FAIL b2b_ready_drop: got %b want 0", Ready);
        end
        wait_ready(lat, prod);
        Run = 1'b0;
        exp = sb.pop_front();
        n_cmp++;
        if (lat + 1 !== 33) begin
            n_fail++; $display("FAIL b2b_spacing: got %0d want 33", lat + 1);
        end
        n_cmp++;
        if (prod !== exp) begin
            n_fail++; $display("FAIL b2b_second: got %h want %h", prod, exp);
        end
        for (int i = 0; i < 4; i++) tick();
        n_cmp++;
        if (Ready !== 1'b1 || Product !== exp) begin
            n_fail++; $display("FAIL b2b_hold: got ready %b product %h want 1 %h", Ready, Product, exp);
        end
    endtask

    initial begin
        Reset = 1'b0; Run = 1'b0; Multiplicand = '0; Multiplier = '0;
        test_reset();
        test_basic();
        test_carry();
        test_random();
        test_run_busy();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
